regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between NUM_REQ requesters, for example the ALU write-back and the load unit.
- Arbitration is round-robin with a valid/ready handshake per requester.
- The selected write passes through a registered output stage that drives the register file write_reg / write_data / write_enable inputs.
- Writes to register 0 are accepted but suppressed, keeping x0 hard-wired to zero.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_write_arbiter_rr_arbiter.sv | 54 +++++
 rtl/regfile_write_arbiter.sv | 79 +++++++
 tb/tb_regfile_write_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants for the write-port arbitration slice.
//   REG_ADDR_W : register index width
//   REG_DATA_W : register data width
//   REG_COUNT  : number of architectural registers
//   REG_ZERO   : index of the hard-wired zero register
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Generic round-robin grant with a pointer register and one-hot output.
// Ports:
//   clock, reset   : system clock, async active-low reset
//   enable         : 0 forces grant to all-zero
//   valid[N-1:0]   : per-requester request
//   grant[N-1:0]   : one-hot grant (combinational from valid/ptr)
//   grant_idx      : index of the granted requester (valid when grant_any)
//   grant_any      : a grant (hence a handshake) happens this cycle
//   ptr            : current round-robin pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any,
  output logic [PTR_W-1:0]   ptr
);

  // Scan from ptr upward with wraparound; the first valid requester wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (enable && !grant_any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

  // A grant is only ever issued to a valid requester, so every grant is a
  // completed handshake and moves the pointer just past the winner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_any) begin
      if (grant_idx == PTR_W'(NUM_REQ - 1))
        ptr <= '0;
      else
        ptr <= grant_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ requesters using
// round-robin arbitration, with a registered output stage.
// Ports:
//   clock, reset : system clock, async active-low reset
//   arb_enable   : 0 blocks all grants in the same cycle
//   req_valid    : per-requester write request
//   req_addr     : packed per-requester register index
//   req_data     : packed per-requester write data
//   req_ready    : one-hot grant (handshake = valid & ready)
//   wr_reg       : register file write index (registered)
//   wr_data      : register file write data (registered)
//   wr_enable    : register file write strobe (registered)
//   zero_drop    : pulse when an accepted write to register 0 was dropped
//   rr_ptr_o     : round-robin pointer, for debug
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      arb_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         wr_reg,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      wr_enable,
  output logic                      zero_drop,
  output logic [PTR_W-1:0]          rr_ptr_o
);

  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_is_zero;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .clock     (clock),
    .reset     (reset),
    .enable    (arb_enable),
    .valid     (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any),
    .ptr       (rr_ptr_o)
  );

  assign sel_addr    = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data    = req_data[grant_idx*DATA_W +: DATA_W];
  assign sel_is_zero = (sel_addr == ADDR_W'(REG_ZERO));

  // Writes to x0 are accepted and still update wr_reg/wr_data, but the
  // strobe is withheld so the register stays zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_reg    <= '0;
      wr_data   <= '0;
      wr_enable <= 1'b0;
      zero_drop <= 1'b0;
    end else begin
      wr_enable <= grant_any && !sel_is_zero;
      zero_drop <= grant_any && sel_is_zero;
      if (grant_any) begin
        wr_reg  <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clock;
  logic                      reset;
  logic                      arb_enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         wr_reg;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_enable;
  logic                      zero_drop;
  logic [0:0]                rr_ptr_o;

  logic [DATA_W-1:0] rf [32];

  int n_checks;
  int n_fail;

  regfile_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .arb_enable (arb_enable),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .wr_enable  (wr_enable),
    .zero_drop  (zero_drop),
    .rr_ptr_o   (rr_ptr_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: commits on the rising edge, x0 never written.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_enable && wr_reg != 5'd0) begin
      rf[wr_reg] <= wr_data;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    arb_enable = 1'b1;
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // 1. reset state
    #20;
    check_val("rst_ready", 64'(req_ready), 64'h0);
    check_val("rst_wr_en", 64'(wr_enable), 64'h0);
    check_val("rst_wr_reg", 64'(wr_reg), 64'h0);
    check_val("rst_wr_data", 64'(wr_data), 64'h0);
    check_val("rst_ptr", 64'(rr_ptr_o), 64'h0);
    check_val("rst_zdrop", 64'(zero_drop), 64'h0);
    reset = 1'b1;
    tick();

    // 2. single write from req0
    set_req(2'b01, 5'd1, 32'hAABBCCDD, 5'd0, 32'h0);
    #1;
    check_val("t2_ready", 64'(req_ready), 64'h1);
    tick();
    set_req(2'b00, 5'd1, 32'hAABBCCDD, 5'd0, 32'h0);
    check_val("t2_wr_en", 64'(wr_enable), 64'h1);
    check_val("t2_wr_reg", 64'(wr_reg), 64'h1);
    check_val("t2_wr_data", 64'(wr_data), 64'hAABBCCDD);
    check_val("t2_ptr", 64'(rr_ptr_o), 64'h1);
    tick();
    check_val("t2_rf1", 64'(rf[1]), 64'hAABBCCDD);
    check_val("t2_idle_en", 64'(wr_enable), 64'h0);
    check_val("t2_hold_reg", 64'(wr_reg), 64'h1);

    // 3. both valid from reset: alternating grants, no bubbles
    reset = 1'b0;
    set_req(2'b11, 5'd2, 32'h12345678, 5'd3, 32'hFACEBEEF);
    #3;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("t3_ready%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      check_val($sformatf("t3_wr_en%0d", k), 64'(wr_enable), 64'h1);
      check_val($sformatf("t3_wr_reg%0d", k), 64'(wr_reg), (k % 2 == 0) ? 64'h2 : 64'h3);
    end
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    check_val("t3_rf2", 64'(rf[2]), 64'h12345678);
    check_val("t3_rf3", 64'(rf[3]), 64'hFACEBEEF);
    check_val("t3_ptr", 64'(rr_ptr_o), 64'h0);

    // 4. write to x0 is dropped
    set_req(2'b10, 5'd0, 32'h0, 5'd0, 32'hDEADBEEF);
    #1;
    check_val("t4_ready", 64'(req_ready), 64'h2);
    tick();
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    check_val("t4_wr_en", 64'(wr_enable), 64'h0);
    check_val("t4_zdrop", 64'(zero_drop), 64'h1);
    check_val("t4_wr_data", 64'(wr_data), 64'hDEADBEEF);
    check_val("t4_ptr", 64'(rr_ptr_o), 64'h0);
    tick();
    check_val("t4_zdrop_clr", 64'(zero_drop), 64'h0);
    check_val("t4_rf0", 64'(rf[0]), 64'h0);

    // 5. same destination from both: round-robin order, last wins
    set_req(2'b11, 5'd5, 32'h11111111, 5'd5, 32'h22222222);
    #1;
    check_val("t5_ready0", 64'(req_ready), 64'h1);
    tick();
    check_val("t5_ready1", 64'(req_ready), 64'h2);
    check_val("t5_data0", 64'(wr_data), 64'h11111111);
    tick();
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    check_val("t5_data1", 64'(wr_data), 64'h22222222);
    tick();
    check_val("t5_rf5", 64'(rf[5]), 64'h22222222);

    // 6. arb_enable low: in-flight write still issues, grants blocked
    set_req(2'b01, 5'd7, 32'h00000077, 5'd9, 32'h00000099);
    #1;
    check_val("t6_ready_pre", 64'(req_ready), 64'h1);
    tick();
    set_req(2'b11, 5'd7, 32'h00000077, 5'd9, 32'h00000099);
    arb_enable = 1'b0;
    #1;
    check_val("t6_ready_off", 64'(req_ready), 64'h0);
    check_val("t6_inflight_en", 64'(wr_enable), 64'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val($sformatf("t6_ready_dis%0d", k), 64'(req_ready), 64'h0);
      check_val($sformatf("t6_wr_en_dis%0d", k), 64'(wr_enable), 64'h0);
    end
    check_val("t6_ptr_saved", 64'(rr_ptr_o), 64'h1);
    check_val("t6_rf7", 64'(rf[7]), 64'h77);
    arb_enable = 1'b1;
    #1;
    check_val("t6_resume", 64'(req_ready), 64'h2);
    tick();
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    check_val("t6_resume_reg", 64'(wr_reg), 64'h9);
    check_val("t6_resume_en", 64'(wr_enable), 64'h1);

    // 1b. async reset mid-transfer clears outputs immediately
    #2;
    reset = 1'b0;
    #1;
    check_val("mid_rst_en", 64'(wr_enable), 64'h0);
    check_val("mid_rst_reg", 64'(wr_reg), 64'h0);
    check_val("mid_rst_data", 64'(wr_data), 64'h0);
    check_val("mid_rst_ptr", 64'(rr_ptr_o), 64'h0);
    tick();
    reset = 1'b1;
    check_val("mid_rst_hold_en", 64'(wr_enable), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
